mesi_cpu_req_stage: RTL and testbench



---
 rtl/mesi_cpu_req_stage.sv | 171 +++++++++++++++++
 tb/tb_mesi_cpu_req_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mesi_cpu_req_stage.sv
// Per-CPU request stage in front of the MESI coherence controller.
// It buffers CPU read/write instructions and issues each one as a broadcast command held until acked.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | no command on the bus; loads the FIFO head when one exists
//   ST_REQ  | broadcast command held on the bus until mbus_ack_i
module mesi_cpu_req_stage #(
    parameter int ADDR_WIDTH      = 32,
    parameter int MBUS_CMD_WIDTH  = 3,
    parameter int FIFO_DEPTH      = 2,
    parameter int FIFO_DEPTH_LOG2 = 1,
    parameter int TIMEOUT         = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                tb_ins_i,
    input  logic [ADDR_WIDTH-1:0]     tb_ins_addr_i,
    output logic                      tb_ins_ack_o,
    output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o,
    output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
    input  logic                      mbus_ack_i,
    output logic                      busy_o,
    output logic                      illegal_o,
    output logic                      err_timeout_o
);

    localparam logic [3:0] INS_RD = 4'd1;
    localparam logic [3:0] INS_WR = 4'd2;

    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_NOP      = MBUS_CMD_WIDTH'(0);
    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_WR_BROAD = MBUS_CMD_WIDTH'(3);
    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_RD_BROAD = MBUS_CMD_WIDTH'(4);

    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);
    localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE  = (FIFO_DEPTH_LOG2 + 1)'(1);
    localparam logic [FIFO_DEPTH_LOG2:0]   CNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH);

    localparam logic [15:0] TMR_ONE = 16'd1;
    localparam logic [15:0] TMR_SAT = 16'(TIMEOUT - 1);
    localparam logic [15:0] TMR_PRE = 16'(TIMEOUT - 2);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [FIFO_DEPTH_LOG2-1:0]  wptr_q, wptr_d;
    logic [FIFO_DEPTH_LOG2-1:0]  rptr_q, rptr_d;
    logic [FIFO_DEPTH_LOG2:0]    cnt_q, cnt_d;
    logic                        fifo_wr_q   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]       fifo_addr_q [FIFO_DEPTH];

    logic                        ack_q, ack_d;
    logic                        ill_q, ill_d;
    logic                        busy_q, busy_d;
    logic                        err_q, err_d;
    logic [MBUS_CMD_WIDTH-1:0]   cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [15:0]                 tmr_q, tmr_d;

    logic fifo_full;
    logic fifo_empty;
    logic ins_valid;
    logic ins_legal;
    logic accept;
    logic push;
    logic pop;

    assign fifo_full  = (cnt_q == CNT_FULL);
    assign fifo_empty = (cnt_q == '0);
    assign ins_valid  = (tb_ins_i != 4'd0);
    assign ins_legal  = (tb_ins_i == INS_RD) || (tb_ins_i == INS_WR);
    assign pop        = (state_q == ST_REQ) && mbus_ack_i;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign accept     = ins_valid && !ack_q && (!fifo_full || pop);
    assign push       = accept && ins_legal;

    always_comb begin
        ack_d  = accept;
        ill_d  = accept && !ins_legal;
        wptr_d = push ? (wptr_q + PTR_ONE) : wptr_q;
        rptr_d = pop  ? (rptr_q + PTR_ONE) : rptr_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        busy_d = !fifo_empty || (state_q != ST_IDLE);
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        tmr_d   = tmr_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_REQ;
                    cmd_d   = fifo_wr_q[rptr_q] ? CMD_WR_BROAD : CMD_RD_BROAD;
                    addr_d  = fifo_addr_q[rptr_q];
                    tmr_d   = '0;
                end
            end
            ST_REQ: begin
                if (mbus_ack_i) begin
                    state_d = ST_IDLE;
                    cmd_d   = CMD_NOP;
                end else if (tmr_q != TMR_SAT) begin
                    // Counter saturates at TIMEOUT-1; the flag rises as it gets there.
                    tmr_d = tmr_q + TMR_ONE;
                    if (tmr_q == TMR_PRE) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cmd_d   = CMD_NOP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            ill_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            ill_q   <= ill_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            tmr_q   <= tmr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wr_q[wptr_q]   <= (tb_ins_i == INS_WR);
            fifo_addr_q[wptr_q] <= tb_ins_addr_i;
        end
    end

    assign tb_ins_ack_o  = ack_q;
    assign illegal_o     = ill_q;
    assign busy_o        = busy_q;
    assign err_timeout_o = err_q;
    assign mbus_cmd_o    = cmd_q;
    assign mbus_addr_o   = addr_q;

endmodule

// File: tb/tb_mesi_cpu_req_stage.sv
// Directed bench for mesi_cpu_req_stage: hand-computed cycle-by-cycle expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mesi_cpu_req_stage;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    tb_ins;
    logic [AW-1:0] tb_addr;
    logic          tb_ack;
    logic [2:0]    mcmd;
    logic [AW-1:0] maddr;
    logic          mack;
    logic          busy;
    logic          illegal;
    logic          err;

    int n_chk  = 0;
    int n_pass = 0;

    mesi_cpu_req_stage #(
        .ADDR_WIDTH      (AW),
        .MBUS_CMD_WIDTH  (3),
        .FIFO_DEPTH      (2),
        .FIFO_DEPTH_LOG2 (1),
        .TIMEOUT         (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tb_ins_i      (tb_ins),
        .tb_ins_addr_i (tb_addr),
        .tb_ins_ack_o  (tb_ack),
        .mbus_cmd_o    (mcmd),
        .mbus_addr_o   (maddr),
        .mbus_ack_i    (mack),
        .busy_o        (busy),
        .illegal_o     (illegal),
        .err_timeout_o (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_bus(input string tag, input logic [2:0] c, input logic [AW-1:0] a);
        check({tag, "_cmd"}, 64'(mcmd), 64'(c));
        check({tag, "_addr"}, 64'(maddr), 64'(a));
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_ack"}, 64'(tb_ack), 64'd0);
        check({tag, "_ill"}, 64'(illegal), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        chk_bus(tag, 3'd0, '0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        tb_ins  = 4'd0;
        tb_addr = '0;
        mack    = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        // Single RD: instruction at cycle 5, bus ack at cycle 9.
        do_reset();
        chk_reset_vals("rst");
        step(5);
        tb_ins = 4'd1; tb_addr = 32'h100;
        step();                                   // 6
        check("rd_ack6", 64'(tb_ack), 64'd1);
        check("rd_cmd6", 64'(mcmd), 64'd0);
        tb_ins = 4'd0;
        step();                                   // 7
        check("rd_ack7", 64'(tb_ack), 64'd0);
        chk_bus("rd7", 3'd4, 32'h100);
        check("rd_busy7", 64'(busy), 64'd1);
        step(2);                                  // 9
        chk_bus("rd9", 3'd4, 32'h100);
        mack = 1'b1;
        step();                                   // 10
        mack = 1'b0;
        chk_bus("rd10", 3'd0, 32'h100);
        step();                                   // 11
        check("rd_busy11", 64'(busy), 64'd0);
        check("rd_cmd11", 64'(mcmd), 64'd0);

        // Two WRs fill the FIFO, RD stalls, then pushes in the same cycle as a pop.
        do_reset();
        tb_ins = 4'd2; tb_addr = 32'h200;
        step();                                   // A+1
        check("st_ack1", 64'(tb_ack), 64'd1);
        tb_ins = 4'd2; tb_addr = 32'h204;
        step();                                   // A+2
        check("st_ack2", 64'(tb_ack), 64'd0);
        chk_bus("st2", 3'd3, 32'h200);
        step();                                   // A+3
        check("st_ack3", 64'(tb_ack), 64'd1);
        tb_ins = 4'd1; tb_addr = 32'h208;
        for (int i = 4; i <= 6; i++) begin
            step();
            check($sformatf("st_stall_ack%0d", i), 64'(tb_ack), 64'd0);
        end
        chk_bus("st6", 3'd3, 32'h200);
        check("st_busy6", 64'(busy), 64'd1);
        mack = 1'b1;
        step();                                   // B+1
        mack = 1'b0;
        check("st_pushpop_ack", 64'(tb_ack), 64'd1);
        chk_bus("st_b1", 3'd0, 32'h200);
        check("st_err", 64'(err), 64'd0);
        tb_ins = 4'd0;
        step();                                   // B+2
        chk_bus("st_b2", 3'd3, 32'h204);
        check("st_ack_b2", 64'(tb_ack), 64'd0);
        mack = 1'b1;
        step();                                   // B+3
        mack = 1'b0;
        chk_bus("st_b3", 3'd0, 32'h204);
        step();                                   // B+4
        chk_bus("st_b4", 3'd4, 32'h208);
        mack = 1'b1;
        step();                                   // B+5
        mack = 1'b0;
        chk_bus("st_b5", 3'd0, 32'h208);
        step();                                   // B+6
        check("st_cmd_b6", 64'(mcmd), 64'd0);
        check("st_busy_b6", 64'(busy), 64'd0);

        // Illegal opcode: ack and illegal together, nothing issued.
        do_reset();
        tb_ins = 4'd7; tb_addr = 32'h500;
        step();
        check("il_ack", 64'(tb_ack), 64'd1);
        check("il_pulse", 64'(illegal), 64'd1);
        tb_ins = 4'd0;
        step();
        check("il_ack_off", 64'(tb_ack), 64'd0);
        check("il_pulse_off", 64'(illegal), 64'd0);
        check("il_busy", 64'(busy), 64'd0);
        step();
        check("il_cmd", 64'(mcmd), 64'd0);

        // Timeout with TIMEOUT=8: flag 7 cycles after the command appears.
        do_reset();
        tb_ins = 4'd1; tb_addr = 32'h300;
        step();
        tb_ins = 4'd0;
        step();                                   // C
        chk_bus("to_c0", 3'd4, 32'h300);
        step(6);                                  // C+6
        check("to_err6", 64'(err), 64'd0);
        step();                                   // C+7
        check("to_err7", 64'(err), 64'd1);
        step(3);                                  // C+10
        check("to_err10", 64'(err), 64'd1);
        chk_bus("to_c10", 3'd4, 32'h300);
        mack = 1'b1;
        step();                                   // C+11
        mack = 1'b0;
        chk_bus("to_c11", 3'd0, 32'h300);
        check("to_err11", 64'(err), 64'd1);
        step();
        check("to_busy12", 64'(busy), 64'd0);

        // Reset while REQ holds with two entries queued.
        do_reset();
        tb_ins = 4'd1; tb_addr = 32'h400;
        step();                                   // N+1
        tb_ins = 4'd2; tb_addr = 32'h404;
        step();                                   // N+2
        step();                                   // N+3
        check("mr_ack", 64'(tb_ack), 64'd1);
        chk_bus("mr_pre", 3'd4, 32'h400);
        tb_ins = 4'd0;
        rst = 1'b1;
        step();
        chk_reset_vals("mr_rst");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("mr_cmd%0d", i), 64'(mcmd), 64'd0);
        end
        check("mr_busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
